// File: rtl/sad_log_pkg.sv
// sad_log_pkg: shared widths, log entry layout and done-FSM encoding.
// Defining SAD_LOG_PC_EN adds a pc field to each logged entry.
package sad_log_pkg;
    localparam int LOG_DATA_W = 32;

    typedef struct packed {
        logic [LOG_DATA_W-1:0] v1;
        logic [LOG_DATA_W-1:0] v0;
`ifdef SAD_LOG_PC_EN
        logic [LOG_DATA_W-1:0] pc;
`endif
    } log_entry_t;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_t;
endpackage

// File: rtl/sad_log_fifo.sv
// sad_log_fifo: synchronous show-ahead FIFO with a registered head that holds its last value when empty.
module sad_log_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    always_comb begin
        level   = wr_q - rd_q;
        full    = level[AW];
        empty   = wr_q == rd_q;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q + {{AW{1'b0}}, do_push};
        rd_d    = rd_q + {{AW{1'b0}}, do_pop};
        // when the FIFO drains to just the incoming word, bypass it straight to the head
        head_d  = (wr_d == rd_d) ? head_q : (wr_q == rd_d) ? wdata : mem_q[rd_d[AW-1:0]];
        head    = head_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/sad_result_logger.sv
// sad_result_logger: logs {v1,v0} changes into a FIFO, counts drops, flags done on a stalled PC.
// Optional SAD_LOG_PC_EN stores the PC with each entry and drives out_pc.
import sad_log_pkg::*;

module sad_result_logger #(
    parameter int DEPTH       = 8,
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LOG_DATA_W-1:0]  v0_in,
    input  logic [LOG_DATA_W-1:0]  v1_in,
    input  logic [LOG_DATA_W-1:0]  pc_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LOG_DATA_W-1:0]  out_v0,
    output logic [LOG_DATA_W-1:0]  out_v1,
    output logic [LOG_DATA_W-1:0]  out_pc,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_count,
    output logic                   done
);
    localparam int CW = $clog2(STALL_LIMIT);

    logic [LOG_DATA_W-1:0] prev_v0_q, prev_v0_d, prev_v1_q, prev_v1_d, prev_pc_q, prev_pc_d;
    logic [CNT_W-1:0]      drop_count_q, drop_count_d;
    logic                  overflow_q, overflow_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    state_t                state_q, state_d;
    logic                  push, pop, full, empty, drop, pc_same;
    log_entry_t            wentry, hentry;

    always_comb begin
        prev_v0_d    = v0_in;
        prev_v1_d    = v1_in;
        prev_pc_d    = pc_in;
        push         = {v1_in, v0_in} != {prev_v1_q, prev_v0_q};
        pop          = out_valid && out_ready;
        drop         = push && full && !pop;
        overflow_d   = overflow_q || drop;
        drop_count_d = (drop && !(&drop_count_q)) ? drop_count_q + CNT_W'(1) : drop_count_q;
        wentry.v0    = v0_in;
        wentry.v1    = v1_in;
`ifdef SAD_LOG_PC_EN
        wentry.pc    = pc_in;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_v0_q    <= '0;
            prev_v1_q    <= '0;
            prev_pc_q    <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            cnt_q        <= '0;
        end else begin
            prev_v0_q    <= prev_v0_d;
            prev_v1_q    <= prev_v1_d;
            prev_pc_q    <= prev_pc_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            cnt_q        <= cnt_d;
        end
    end

    sad_log_fifo #(
        .DEPTH(DEPTH),
        .W    ($bits(log_entry_t))
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata(wentry),
        .head (hentry),
        .full (full),
        .empty(empty),
        .level(level)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // counter freezes once halted; done is sticky until reset
    always_comb begin
        pc_same = pc_in == prev_pc_q;
        state_d = (state_q == ST_RUN && pc_same && cnt_q == CW'(STALL_LIMIT - 1)) ? ST_HALT : state_q;
        cnt_d   = (state_q == ST_HALT) ? cnt_q : pc_same ? cnt_q + CW'(1) : '0;
    end

    always_comb begin
        done       = state_q == ST_HALT;
        out_valid  = !empty;
        out_v0     = hentry.v0;
        out_v1     = hentry.v1;
        overflow   = overflow_q;
        drop_count = drop_count_q;
`ifdef SAD_LOG_PC_EN
        out_pc     = hentry.pc;
`else
        out_pc     = 32'd0;
`endif
    end
endmodule

// File: tb/tb_sad_result_logger.sv
// tb_sad_result_logger: directed stimulus with a scoreboard queue checked by a pop monitor.
module tb_sad_result_logger;
    logic        clk = 1'b0, rst = 1'b1, out_ready = 1'b0;
    logic [31:0] v0_in = '0, v1_in = '0, pc_in = '0;
    logic        out_valid, overflow, done;
    logic [31:0] out_v0, out_v1, out_pc;
    logic [3:0]  level;
    logic [7:0]  drop_count;

    typedef struct {
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0, errors = 0;
    bit   pc_run = 1'b0;

    sad_result_logger dut (
        .clk       (clk),
        .rst       (rst),
        .v0_in     (v0_in),
        .v1_in     (v1_in),
        .pc_in     (pc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_v0    (out_v0),
        .out_v1    (out_v1),
        .out_pc    (out_pc),
        .level     (level),
        .overflow  (overflow),
        .drop_count(drop_count),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (pc_run) pc_in = pc_in + 32'd4;
    endtask

    task automatic expect_push(input logic [31:0] v0, input logic [31:0] v1);
        exp_t e;
        e.v0 = v0;
        e.v1 = v1;
`ifdef SAD_LOG_PC_EN
        e.pc = pc_in;
`else
        e.pc = 32'd0;
`endif
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual=%h expected=none", out_v0);
            end else begin
                mon_e = sb.pop_front();
                chk("pop_v0", out_v0, mon_e.v0);
                chk("pop_v1", out_v1, mon_e.v1);
                chk("pop_pc", out_pc, mon_e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tick;
        tick;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drops", drop_count, 0);
        chk("rst_v0", out_v0, 0);
        chk("rst_v1", out_v1, 0);
        chk("rst_pc", out_pc, 0);
        rst    = 1'b0;
        pc_in  = 32'h1000;
        pc_run = 1'b1;
        tick;
        chk("idle_valid", out_valid, 0);

        v0_in = 32'h15;
        expect_push(32'h15, 32'h0);
        tick;
        chk("first_valid", out_valid, 1);
        chk("first_v0", out_v0, 32'h15);
        chk("first_level", level, 1);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("pop_empty_valid", out_valid, 0);
        chk("pop_empty_level", level, 0);
        chk("empty_hold_v0", out_v0, 32'h15);

        for (int i = 0; i < 10; i++) begin
            v0_in = 32'h100 + i;
            if (i < 8) expect_push(v0_in, 32'h0);
            tick;
        end
        chk("full_level", level, 8);
        chk("full_overflow", overflow, 1);
        chk("full_drops", drop_count, 2);
        chk("full_head", out_v0, 32'h100);

        out_ready = 1'b1;
        v0_in = 32'h200;
        expect_push(32'h200, 32'h0);
        tick;
        chk("pushpop_level", level, 8);
        chk("pushpop_drops", drop_count, 2);
        chk("pushpop_head", out_v0, 32'h101);
        for (int n = 0; n < 20 && out_valid; n++) tick;
        out_ready = 1'b0;
        chk("drain_valid", out_valid, 0);
        chk("drain_level", level, 0);
        chk("drain_sb", sb.size(), 0);

        pc_run = 1'b0;
        pc_in  = 32'h40;
        tick;
        repeat (15) tick;
        chk("stall15_done", done, 0);
        pc_in = 32'h44;
        tick;
        chk("pc_change_done", done, 0);
        pc_in = 32'h40;
        tick;
        repeat (15) tick;
        chk("stall_pre_done", done, 0);
        tick;
        chk("stall16_done", done, 1);
        pc_in = 32'h80;
        repeat (3) tick;
        chk("done_sticky", done, 1);

        v1_in = 32'h5;
        expect_push(32'h200, 32'h5);
        tick;
        chk("halt_log_valid", out_valid, 1);
        chk("halt_log_v1", out_v1, 32'h5);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("halt_log_level", level, 0);

        for (int i = 0; i < 5; i++) begin
            v0_in = 32'h300 + i;
            tick;
        end
        chk("pre_rst_level", level, 5);
        chk("pre_rst_done", done, 1);
        rst   = 1'b1;
        v0_in = '0;
        v1_in = '0;
        pc_in = '0;
        tick;
        chk("rst2_valid", out_valid, 0);
        chk("rst2_level", level, 0);
        chk("rst2_overflow", overflow, 0);
        chk("rst2_drops", drop_count, 0);
        chk("rst2_done", done, 0);
        chk("rst2_v0", out_v0, 0);
        chk("rst2_v1", out_v1, 0);
        chk("rst2_pc", out_pc, 0);
        rst = 1'b0;
        tick;
        chk("post_rst_valid", out_valid, 0);
        chk("end_sb", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
